return_address_stack: RTL

Return-address stack that consumes resolved `jal`/`jalr` events and tracks the procedure call/return nesting they imply. Calls (link-register writes) push `pc + 4`, and returns (`jalr` through a link register) pop. The block checks every return target against the popped prediction and raises a one-cycle mispredict pulse. It sits beside the jump ALUs and feeds return-target prediction to fetch.

---
 rtl/rv_link_pkg.sv | 21 ++
 rtl/ras_hint_decode.sv | 36 +++
 rtl/return_address_stack.sv | 108 ++++++++++
 3 files changed

// File: rtl/rv_link_pkg.sv
// Shared definitions for link-register aware jump handling: register width,
// link register indices and the return-address-stack action encoding.
package rv_link_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] LINK_RA = 5'd1;
   localparam logic [4:0] LINK_T0 = 5'd5;

   typedef enum logic [1:0] {
      RAS_NONE,
      RAS_PUSH,
      RAS_POP,
      RAS_POP_PUSH
   } ras_action_t;

   function automatic logic is_link(input logic [4:0] idx);
      return (idx == LINK_RA) || (idx == LINK_T0);
   endfunction

endpackage

// File: rtl/ras_hint_decode.sv
// Classifies a resolved jal/jalr into a return-address-stack action using
// the link-register usage of rd and rs1.
module ras_hint_decode
   import rv_link_pkg::*;
(
   input  logic        jump_valid,
   input  logic        jump_is_jalr,
   input  logic [4:0]  rd_index,
   input  logic [4:0]  rs1_index,
   output ras_action_t action
);

   logic rd_link;
   logic rs1_link;

   assign rd_link  = is_link(rd_index);
   assign rs1_link = is_link(rs1_index);

   always_comb begin
      action = RAS_NONE;
      if (jump_valid) begin
         if (!jump_is_jalr) begin
            action = rd_link ? RAS_PUSH : RAS_NONE;
         end else begin
            case ({rd_link, rs1_link})
               2'b01:   action = RAS_POP;
               2'b10:   action = RAS_PUSH;
               // ra/t0 swap is a coroutine switch; same register is a plain call
               2'b11:   action = (rd_index != rs1_index) ? RAS_POP_PUSH : RAS_PUSH;
               default: action = RAS_NONE;
            endcase
         end
      end
   end

endmodule

// File: rtl/return_address_stack.sv
// Circular return-address stack: pushes pc+4 on calls, pops on returns and
// flags a one-cycle mispredict when the popped prediction misses.
module return_address_stack
   import rv_link_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       jump_valid,
   input  logic                       jump_is_jalr,
   input  logic [4:0]                 rd_index,
   input  logic [4:0]                 rs1_index,
   input  logic [XLEN-1:0]            pc,
   input  logic [XLEN-1:0]            next_pc,
   output logic                       top_valid,
   output logic [XLEN-1:0]            top_value,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       mispredict
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   ras_action_t action;

   logic [XLEN-1:0]  entries_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mispredict_q, mispredict_d;

   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic [XLEN-1:0]  link_addr;
   logic             stack_empty;
   logic             target_hit;

   ras_hint_decode u_decode (
      .jump_valid   (jump_valid),
      .jump_is_jalr (jump_is_jalr),
      .rd_index     (rd_index),
      .rs1_index    (rs1_index),
      .action       (action)
   );

   assign link_addr   = pc + 32'd4;
   assign stack_empty = (count_q == '0);
   assign top_valid   = !stack_empty;
   assign top_value   = stack_empty ? '0 : entries_q[ptr_q];
   assign count       = count_q;
   assign mispredict  = mispredict_q;
   // bit 0 of a jalr target is architecturally cleared, so ignore it in the compare
   assign target_hit  = (top_value == (next_pc & ~32'd1));

   always_comb begin
      ptr_d        = ptr_q;
      count_d      = count_q;
      mispredict_d = 1'b0;
      wr_en        = 1'b0;
      wr_idx       = ptr_q;
      if (flush) begin
         ptr_d   = '0;
         count_d = '0;
      end else begin
         case (action)
            RAS_PUSH: begin
               ptr_d  = ptr_q + PTR_W'(1);
               wr_idx = ptr_q + PTR_W'(1);
               wr_en  = 1'b1;
               if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
            end
            RAS_POP: begin
               mispredict_d = stack_empty || !target_hit;
               if (!stack_empty) begin
                  ptr_d   = ptr_q - PTR_W'(1);
                  count_d = count_q - CNT_W'(1);
               end
            end
            RAS_POP_PUSH: begin
               mispredict_d = stack_empty || !target_hit;
               wr_en        = 1'b1;
               if (stack_empty) begin
                  ptr_d   = ptr_q + PTR_W'(1);
                  wr_idx  = ptr_q + PTR_W'(1);
                  count_d = CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q        <= '0;
         count_q      <= '0;
         mispredict_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      end else begin
         ptr_q        <= ptr_d;
         count_q      <= count_d;
         mispredict_q <= mispredict_d;
         if (wr_en) entries_q[wr_idx] <= link_addr;
      end
   end

endmodule
